// File: rtl/wvb_rd_arb_pkg.sv
// Shared definitions for the waveform-buffer readout arbiter.
// Optional feature macro: WVB_RD_ARB_HDR_WORD_EN (header word ahead of each event).
package wvb_rd_arb_pkg;

  localparam int CHAN_IDX_WIDTH = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_HDR   = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Header word layout, LSB first: ltc, then nwords (adr_w+1 bits), then chan.
  function automatic int hdr_ltc_lsb();
    return 0;
  endfunction

  function automatic int hdr_nwords_lsb(input int ltc_w);
    return ltc_w;
  endfunction

  function automatic int hdr_chan_lsb(input int ltc_w, input int adr_w);
    return ltc_w + adr_w + 1;
  endfunction

endpackage

// File: rtl/wvb_rd_skid.sv
// Small FWFT FIFO behind the BRAM read pipeline. Reads are only issued when
// enough slots are free to hold every word already in flight, so a push
// never meets a full FIFO.
module wvb_rd_skid #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign free_cnt  = CW'(DEPTH) - count_q;
  assign pop       = out_valid && out_ready;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // State registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wvb_rd_arb.sv
// Round-robin readout scheduler for the per-channel waveform buffers.
// Grants one non-empty header FIFO at a time, pops its header, reads the
// waveform words start..stop (wrapping) and streams them out.
// Optional feature macro: WVB_RD_ARB_HDR_WORD_EN emits a header word first.
// Handshake: a word transfers on dout when dout_valid && dout_ready are both
// high at a clock edge; dout_* hold steady while dout_valid && !dout_ready.
module wvb_rd_arb
  import wvb_rd_arb_pkg::*;
#(
  parameter int P_N_CHAN     = 24,
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 128,
  parameter int P_LTC_WIDTH  = 48,
  parameter int P_RD_LAT     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arb_en,
  input  logic [P_N_CHAN-1:0]                hdr_empty,
  output logic [P_N_CHAN-1:0]                hdr_rdreq,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    hdr_start_addr,
  input  logic [P_N_CHAN*P_ADR_WIDTH-1:0]    hdr_stop_addr,
  input  logic [P_N_CHAN*P_LTC_WIDTH-1:0]    hdr_ltc,
  output logic [P_ADR_WIDTH-1:0]             wvb_rd_addr,
  output logic [P_N_CHAN-1:0]                wvb_rd_en,
  input  logic [P_N_CHAN*P_DATA_WIDTH-1:0]   wvb_rd_data,
  output logic [P_N_CHAN-1:0]                rd_done,
  output logic [P_ADR_WIDTH-1:0]             rd_ptr,
  output logic [P_DATA_WIDTH-1:0]            dout_data,
  output logic [CHAN_IDX_WIDTH-1:0]          dout_chan,
  output logic                               dout_valid,
  output logic                               dout_last,
  input  logic                               dout_ready,
  output state_e                             dbg_state
);

  localparam int SKID_DEPTH = P_RD_LAT + 2;
  localparam int SKID_CW    = $clog2(SKID_DEPTH + 1);

  state_e                      state_q, state_d;
  logic [CHAN_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CHAN_IDX_WIDTH-1:0]   chan_q, chan_d;
  logic [P_ADR_WIDTH-1:0]      rd_addr_q, rd_addr_d;
  logic [P_ADR_WIDTH-1:0]      stop_q, stop_d;
  logic [P_RD_LAT-1:0]         pipe_vld_q, pipe_vld_d;
  logic [P_RD_LAT-1:0]         pipe_last_q, pipe_last_d;
  logic [P_N_CHAN-1:0]         rd_done_q, rd_done_d;
  logic [P_ADR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;

  logic                        any_req;
  logic                        grant_found;
  logic [CHAN_IDX_WIDTH-1:0]   grant_idx;
  logic [P_ADR_WIDTH-1:0]      sel_start, sel_stop;
  logic                        hdr_pop, hdr_push, rd_issue;
  logic [P_DATA_WIDTH-1:0]     hdr_word, rd_word;
  logic                        skid_push, skid_pop;
  logic [P_DATA_WIDTH:0]       skid_wdata, skid_rdata;
  logic [SKID_CW-1:0]          skid_free;

  assign any_req   = ~&hdr_empty;
  assign sel_start = hdr_start_addr[grant_idx*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign sel_stop  = hdr_stop_addr[grant_idx*P_ADR_WIDTH +: P_ADR_WIDTH];
  assign rd_word   = wvb_rd_data[chan_q*P_DATA_WIDTH +: P_DATA_WIDTH];
  assign skid_pop  = dout_valid && dout_ready;

  // Round-robin search: first non-empty channel after the last grant.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 1; i <= P_N_CHAN; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= P_N_CHAN) idx = idx - P_N_CHAN;
      if (!grant_found && !hdr_empty[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CHAN_IDX_WIDTH'(idx);
      end
    end
  end

  // FSM next-state, read issue and completion pulse.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chan_d       = chan_q;
    rd_addr_d    = rd_addr_q;
    stop_d       = stop_q;
    hdr_pop      = 1'b0;
    hdr_push     = 1'b0;
    rd_issue     = 1'b0;
    rd_done_d    = '0;
    rd_ptr_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (arb_en && any_req) state_d = S_ARB;
      end
      S_ARB: begin
        if (grant_found) begin
          hdr_pop      = 1'b1;
          last_grant_d = grant_idx;
          chan_d       = grant_idx;
          rd_addr_d    = sel_start;
          stop_d       = sel_stop;
`ifdef WVB_RD_ARB_HDR_WORD_EN
          state_d      = S_HDR;
`else
          state_d      = S_READ;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        // Skid is empty here: the previous event fully drained before S_ARB.
        hdr_push = 1'b1;
        state_d  = S_READ;
      end
      S_READ: begin
        // Room for this read plus every read still in the BRAM pipeline.
        if (skid_free >= SKID_CW'(P_RD_LAT + 1)) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == stop_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (skid_pop && dout_last) begin
          rd_done_d[chan_q] = 1'b1;
          rd_ptr_d          = stop_q + 1'b1;
          state_d           = (arb_en && any_req) ? S_ARB : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valid/last tracking through the BRAM read latency.
  always_comb begin
    pipe_vld_d     = '0;
    pipe_last_d    = '0;
    pipe_vld_d[0]  = rd_issue;
    pipe_last_d[0] = rd_issue && (rd_addr_q == stop_q);
    for (int k = 1; k < P_RD_LAT; k++) begin
      pipe_vld_d[k]  = pipe_vld_q[k-1];
      pipe_last_d[k] = pipe_last_q[k-1];
    end
  end

  // Arbiter state registers; reset drops any in-flight event silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= CHAN_IDX_WIDTH'(P_N_CHAN - 1);
      chan_q       <= '0;
      rd_addr_q    <= '0;
      stop_q       <= '0;
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      rd_done_q    <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chan_q       <= chan_d;
      rd_addr_q    <= rd_addr_d;
      stop_q       <= stop_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_last_q  <= pipe_last_d;
      rd_done_q    <= rd_done_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

`ifdef WVB_RD_ARB_HDR_WORD_EN
  localparam int NW_LSB = hdr_nwords_lsb(P_LTC_WIDTH);
  localparam int CH_LSB = hdr_chan_lsb(P_LTC_WIDTH, P_ADR_WIDTH);

  logic [P_LTC_WIDTH-1:0] ltc_q, ltc_d;
  logic [P_ADR_WIDTH:0]   nwords_q, nwords_d;

  // Capture event timestamp and word count at grant time.
  always_comb begin
    ltc_d    = ltc_q;
    nwords_d = nwords_q;
    if (hdr_pop) begin
      ltc_d    = hdr_ltc[grant_idx*P_LTC_WIDTH +: P_LTC_WIDTH];
      nwords_d = {1'b0, sel_stop - sel_start} + 1'b1;
    end
  end

  // Header field registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ltc_q    <= '0;
      nwords_q <= '0;
    end else begin
      ltc_q    <= ltc_d;
      nwords_q <= nwords_d;
    end
  end

  // Assemble the zero-padded header word.
  always_comb begin
    hdr_word = '0;
    hdr_word[hdr_ltc_lsb() +: P_LTC_WIDTH]  = ltc_q;
    hdr_word[NW_LSB +: P_ADR_WIDTH+1]       = nwords_q;
    hdr_word[CH_LSB +: CHAN_IDX_WIDTH]      = chan_q;
  end
`else
  logic unused_ltc;
  assign unused_ltc = ^hdr_ltc;
  assign hdr_word   = '0;
`endif

  assign skid_push  = pipe_vld_q[P_RD_LAT-1] | hdr_push;
  assign skid_wdata = pipe_vld_q[P_RD_LAT-1] ? {pipe_last_q[P_RD_LAT-1], rd_word}
                                             : {1'b0, hdr_word};

  wvb_rd_skid #(
    .DEPTH (SKID_DEPTH),
    .WIDTH (P_DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (skid_push),
    .push_data (skid_wdata),
    .out_ready (dout_ready),
    .out_valid (dout_valid),
    .out_data  (skid_rdata),
    .free_cnt  (skid_free)
  );

  // One-hot header pop and BRAM read enable.
  always_comb begin
    hdr_rdreq = '0;
    wvb_rd_en = '0;
    if (hdr_pop)  hdr_rdreq[grant_idx] = 1'b1;
    if (rd_issue) wvb_rd_en[chan_q]    = 1'b1;
  end

  assign wvb_rd_addr = rd_addr_q;
  assign rd_done     = rd_done_q;
  assign rd_ptr      = rd_ptr_q;
  assign dout_data   = skid_rdata[P_DATA_WIDTH-1:0];
  assign dout_last   = skid_rdata[P_DATA_WIDTH];
  assign dout_chan   = chan_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_wvb_rd_arb.sv
// Bench for wvb_rd_arb: header FIFO and BRAM models, scoreboard of expected
// stream words and completions, directed tests followed by random traffic.
// Optional feature macro: WVB_RD_ARB_HDR_WORD_EN (expects header words).
module tb_wvb_rd_arb;
  import wvb_rd_arb_pkg::*;

  localparam int N   = 24;
  localparam int AW  = 12;
  localparam int DW  = 128;
  localparam int LW  = 48;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 arb_en;
  logic [N-1:0]         hdr_empty;
  logic [N-1:0]         hdr_rdreq;
  logic [N*AW-1:0]      hdr_start_addr;
  logic [N*AW-1:0]      hdr_stop_addr;
  logic [N*LW-1:0]      hdr_ltc;
  logic [AW-1:0]        wvb_rd_addr;
  logic [N-1:0]         wvb_rd_en;
  logic [N*DW-1:0]      wvb_rd_data;
  logic [N-1:0]         rd_done;
  logic [AW-1:0]        rd_ptr;
  logic [DW-1:0]        dout_data;
  logic [4:0]           dout_chan;
  logic                 dout_valid;
  logic                 dout_last;
  logic                 dout_ready;
  state_e               dbg_state;

  wvb_rd_arb #(
    .P_N_CHAN(N), .P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_LTC_WIDTH(LW), .P_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
    .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
    .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr), .hdr_ltc(hdr_ltc),
    .wvb_rd_addr(wvb_rd_addr), .wvb_rd_en(wvb_rd_en), .wvb_rd_data(wvb_rd_data),
    .rd_done(rd_done), .rd_ptr(rd_ptr),
    .dout_data(dout_data), .dout_chan(dout_chan), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [AW-1:0] start;
    logic [AW-1:0] stop;
    logic [LW-1:0] ltc;
  } ev_t;

  ev_t                 hdr_q [N][$];
  logic [5+1+DW-1:0]   exp_q [$];      // {chan, last, data}
  logic [5+AW-1:0]     done_q [$];     // {chan, rd_ptr}
  int                  grant_log [$];
  int                  last_m;
  int                  vectors = 0;
  int                  miscompares = 0;
  int                  bp_mode = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waveform memory contents: unique per (channel, address).
  function automatic logic [DW-1:0] wword(input int c, input int a);
    return {32'(c), 32'(a), 32'hC0DE_0000 ^ 32'(a * 31 + c), ~32'(a)};
  endfunction

  // ---------------- BRAM model, two-cycle read latency ----------------
  logic [DW-1:0] st1 [N];
  logic [DW-1:0] st2 [N];
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (wvb_rd_en[c]) st1[c] <= wword(c, int'(wvb_rd_addr));
      st2[c] <= st1[c];
    end
  end
  always_comb begin
    for (int c = 0; c < N; c++) wvb_rd_data[c*DW +: DW] = st2[c];
  end

  // ---------------- header FIFO model + reference arbiter ----------------
  int            g_exp, c_act, n_w, a_w;
  ev_t           ev;
  logic [DW-1:0] hw;
  always @(posedge clk) begin
    if (!rst_n) begin
      last_m = N - 1;
    end else if (hdr_rdreq != '0) begin
      g_exp = -1;
      for (int i = 1; i <= N; i++) begin
        if (g_exp < 0 && !hdr_empty[(last_m + i) % N]) g_exp = (last_m + i) % N;
      end
      c_act = 0;
      for (int i = N - 1; i >= 0; i--) if (hdr_rdreq[i]) c_act = i;
      chk("rdreq_onehot", $countones(hdr_rdreq), 1);
      chk("rr_grant", c_act, g_exp);
      chk("hdr_avail", hdr_q[c_act].size() != 0, 1);
      if (hdr_q[c_act].size() != 0) begin
        ev  = hdr_q[c_act].pop_front();
        n_w = ((int'(ev.stop) - int'(ev.start)) & ((1 << AW) - 1)) + 1;
`ifdef WVB_RD_ARB_HDR_WORD_EN
        hw = DW'(ev.ltc) | (DW'(n_w) << LW) | (DW'(c_act) << (LW + AW + 1));
        exp_q.push_back({5'(c_act), 1'b0, hw});
`endif
        for (int i = 0; i < n_w; i++) begin
          a_w = (int'(ev.start) + i) & ((1 << AW) - 1);
          exp_q.push_back({5'(c_act), (i == n_w - 1), wword(c_act, a_w)});
        end
        done_q.push_back({5'(c_act), AW'((int'(ev.stop) + 1) & ((1 << AW) - 1))});
      end
      last_m = c_act;
      grant_log.push_back(c_act);
    end
    for (int c = 0; c < N; c++) begin
      hdr_empty[c] <= (hdr_q[c].size() == 0);
      if (hdr_q[c].size() != 0) begin
        hdr_start_addr[c*AW +: AW] <= hdr_q[c][0].start;
        hdr_stop_addr[c*AW +: AW]  <= hdr_q[c][0].stop;
        hdr_ltc[c*LW +: LW]        <= hdr_q[c][0].ltc;
      end else begin
        hdr_start_addr[c*AW +: AW] <= '0;
        hdr_stop_addr[c*AW +: AW]  <= '0;
        hdr_ltc[c*LW +: LW]        <= '0;
      end
    end
  end

  // ---------------- stream / completion monitor ----------------
  logic              stalled = 1'b0;
  logic              armed = 1'b0;
  logic [5+1+DW-1:0] prev_beat;
  logic [5+AW-1:0]   d_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      armed   = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", dout_valid, 1'b1);
        chk("stall_hold", {dout_chan, dout_last, dout_data}, prev_beat);
      end
      if (dout_valid && dout_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("beat", {dout_chan, dout_last, dout_data}, exp_q.pop_front());
        if (dout_last) armed = 1'b1;
      end
      stalled   = dout_valid && !dout_ready;
      prev_beat = {dout_chan, dout_last, dout_data};
      if (rd_done != '0) begin
        chk("done_after_last", armed, 1'b1);
        armed = 1'b0;
        chk("done_expected", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
          d_exp = done_q.pop_front();
          chk("rd_done", rd_done, N'(1) << d_exp[AW +: 5]);
          chk("rd_ptr", rd_ptr, d_exp[AW-1:0]);
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1:       dout_ready = ~dout_ready;
        2:       dout_ready = ($urandom_range(0, 3) != 0);
        default: dout_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic enq(input int c, input int s, input int e, input logic [LW-1:0] l);
    ev_t x;
    x.start = AW'(s);
    x.stop  = AW'(e);
    x.ltc   = l;
    hdr_q[c].push_back(x);
  endtask

  function automatic bit model_busy();
    bit b;
    b = (exp_q.size() != 0) || (done_q.size() != 0) || (dbg_state != S_IDLE);
    for (int c = 0; c < N; c++) if (hdr_q[c].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (model_busy() && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, k < budget, 1'b1);
  endtask

  task automatic wait_state(input state_e s, input int budget, input string tag);
    int k;
    k = 0;
    while (dbg_state !== s && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, k < budget, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, dout_valid, 1'b0);
    chk({tag, "_rdreq"}, hdr_rdreq, '0);
    chk({tag, "_rden"}, wvb_rd_en, '0);
    chk({tag, "_done"}, rd_done, '0);
    chk({tag, "_state"}, dbg_state, S_IDLE);
    chk({tag, "_data"}, {dout_last, dout_data, rd_ptr, wvb_rd_addr}, '0);
  endtask

  task automatic flush_model();
    exp_q.delete();
    done_q.delete();
    for (int c = 0; c < N; c++) hdr_q[c].delete();
  endtask

  // ---------------- directed + random sequence ----------------
  int n0;
  int fair_tbl [6];
  initial begin
    fair_tbl = '{2, 5, 23, 2, 5, 23};
    rst_n  = 1'b0;
    arb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset0");
    rst_n = 1'b1;

    // 1: reset in the middle of an event, then a clean short event
    enq(9, 0, 99, 48'h1);
    wait_state(S_READ, 50, "t1_reach_read");
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_mid");
    rst_n = 1'b1;
    enq(3, 10, 12, 48'hABC);
    wait_idle(200, "t1_idle");
    chk("t1_grant", grant_log[grant_log.size()-1], 3);

    // 2: address wrap
    enq(0, 4094, 1, 48'h22);
    wait_idle(200, "t2_idle");
    chk("t2_grant", grant_log[grant_log.size()-1], 0);

    // 3: fairness across three channels, two events each
    arb_en = 1'b0;
    for (int r = 0; r < 2; r++) begin
      enq(2, 100 * r, 100 * r + 3, 48'h2);
      enq(5, 200 + r, 205 + r, 48'h5);
      enq(23, 4000, 4001 + r, 48'h17);
    end
    n0 = grant_log.size();
    @(posedge clk);
    #1;
    arb_en = 1'b1;
    wait_idle(500, "t3_idle");
    chk("t3_count", grant_log.size() - n0, 6);
    for (int i = 0; i < 6; i++) begin
      if (n0 + i < grant_log.size()) chk("t3_order", grant_log[n0+i], fair_tbl[i]);
    end

    // 4: backpressure toggling every cycle, 64-word event
    bp_mode = 1;
    enq(11, 100, 163, 48'h44);
    wait_idle(600, "t4_idle");
    bp_mode = 0;

    // 5: arb_en dropped mid-event with another channel pending
    enq(4, 0, 31, 48'h55);
    wait_state(S_READ, 50, "t5_reach_read");
    arb_en = 1'b0;
    enq(7, 5, 9, 48'h77);
    wait_state(S_IDLE, 300, "t5_drain");
    repeat (20) @(posedge clk);
    #1;
    chk("t5_held_idle", dbg_state, S_IDLE);
    chk("t5_pending", hdr_q[7].size(), 1);
    chk("t5_last_grant", grant_log[grant_log.size()-1], 4);
    arb_en = 1'b1;
    wait_idle(200, "t5_idle");
    chk("t5_grant7", grant_log[grant_log.size()-1], 7);

    // 6: event with a known timestamp (header word when enabled)
    enq(1, 0, 7, 48'h1234_5678_9ABC);
    wait_idle(200, "t6_idle");

    // random traffic with random backpressure
    bp_mode = 2;
    for (int i = 0; i < 40; i++) begin
      int c, s, len;
      c   = $urandom_range(0, N - 1);
      s   = $urandom_range(0, (1 << AW) - 1);
      len = $urandom_range(1, 24);
      enq(c, s, (s + len - 1) & ((1 << AW) - 1), {16'($urandom()), 32'($urandom())});
      repeat ($urandom_range(0, 12)) @(posedge clk);
      #1;
    end
    wait_idle(8000, "rand_idle");
    bp_mode = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
